bcd_seg_scanner: RTL and testbench
==================================

Name: bcd_seg_scanner

Overview:
- Downstream consumer of the BCD converter output. It latches a packed BCD word and drives a time-multiplexed common-anode/cathode seven-segment display, one digit per scan slot.
- Features: a programmable scan prescaler, optional leading-zero blanking, and a dash glyph for non-decimal nibbles.
- Sits between the BCD converter and the board display pins, for example the score/counter readout.

Parameters:
- DIGITS, 3, number of BCD digits and anode lines (12-bit BCD word for a 2-nibble converter).
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- ACTIVE_LOW, 1, 1 = seg and an pins active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- bcdValue  in  4*DIGITS  packed BCD; digit i = bcdValue[4i+3:4i], digit 0 = least significant. Only valid while load=1, because the upstream bus may be tri-stated otherwise.
- load  in  1  sample bcdValue into the snapshot register this cycle. Driven from the same source as the converter's enable.
- blankEn  in  1  1 = suppress leading zeros.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  DIGITS  one-hot digit select, registered; bit i selects digit i.

Behaviour:
- **Reset (rst=1 at a clk edge):**
  - snapshot=0, prescaler=0, digit index=0.
  - seg and an driven "all off": all 1s if ACTIVE_LOW, all 0s otherwise.
  - rst has priority over load and tick in the same cycle.
- **Snapshot:**
  - On load=1, snapshot <= bcdValue at the clk edge.
  - When load=0, the snapshot holds its value, and X/Z on bcdValue must not propagate.
- **Prescaler:**
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (count == SCAN_DIV-1).
  - The first tick after reset release occurs on the SCAN_DIV-th rising edge.
- **Scan on a tick cycle:**
  - The output registers load the glyph and anode for the current index, computed from the snapshot value before that edge. A load in the same cycle affects only later slots.
  - The index then increments, wrapping DIGITS-1 -> 0.
  - Outputs hold between ticks. This gives one-cycle latency from tick to pins.
  - No dead time between slots.
- **Glyph encoding (active-high form, before polarity):**
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Nibble values 10..15 display a dash, 0x40.
- **Leading-zero blanking:**
  - Digit i (i>0) is blank when blankEn=1 and snapshot digits DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - A blank slot drives seg all off and an all off.
  - blankEn is sampled on the tick cycle.
- **Polarity:** if ACTIVE_LOW=1, seg and an are the bitwise inverse of the active-high form.
- **Width and arithmetic:**
  - Index width is clog2(DIGITS), with a minimum of 1.
  - Prescaler width is clog2(SCAN_DIV).
  - No arithmetic on the BCD digits; nibbles are decoded as-is.
- **Reset mid-scan:** all state returns to reset values. Scanning restarts at digit 0 after a full SCAN_DIV count.

Test Plan (DIGITS=3, SCAN_DIV=4, ACTIVE_LOW=1):
1. Hold rst for 2 cycles, then release -> seg=7'h7F and an=3'b111 until the 4th edge. On that edge, an=3'b110 with seg for snapshot digit 0=0 -> 7'h40.
2. Pulse load with bcdValue=12'h123, blankEn=0 -> successive ticks give an=110/seg=7'h30 (3), an=101/seg=7'h24 (2), an=011/seg=7'h79 (1), then repeat with 110 again.
3. Load 12'h007 with blankEn=1 -> the digit 0 slot gives seg=7'h78 (7), an=110. The digit 1 and digit 2 slots give an=111, seg=7'h7F. Then set blankEn=0 -> those slots show 0 (7'h40) with an=101 and an=011.
4. Load 12'h0A5 with blankEn=1 -> digit 0 shows 5 (7'h12), digit 1 shows a dash (7'h3F), and digit 2 is blanked.
5. Assert load with 12'h999 on the same cycle as a tick while the old snapshot is 12'h123 -> that slot shows the old digit. The next slots show 9 (7'h10). Drive bcdValue to Z while load=0 -> outputs are unaffected.
6. Assert rst at the digit 1 slot, mid-count -> the next edge gives all off and index 0. The first tick after release occurs exactly 4 edges later, on digit 0.

Source files
------------

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner
// Latches a packed BCD word and drives a time-multiplexed seven-segment display,
// one digit per scan slot. A free-running prescaler sets the slot length; on each
// slot boundary the glyph and anode for the current digit are registered onto the
// pins and the digit index advances. Optional leading-zero blanking and a dash
// glyph for nibbles 10..15.

module bcd_seg_scanner #(
    parameter int DIGITS     = 3,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] bcdValue,
    input  logic                load,
    input  logic                blankEn,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{ACTIVE_LOW}};

    logic [4*DIGITS-1:0] snapshot;
    logic [CNT_W-1:0]    scanCount;
    logic [IDX_W-1:0]    digitIdx;
    logic                tick;
    logic [3:0]          curNibble;
    logic [DIGITS-1:0]   curAnode;
    logic                upperZero;
    logic                curBlank;
    logic [6:0]          curGlyph;

    // Seven-segment glyph in active-high {g,f,e,d,c,b,a} form; non-decimal shows a dash.
    function automatic logic [6:0] decodeGlyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Snapshot register: bcdValue is only trusted while load is high (upstream may float).
    always_ff @(posedge clk) begin
        if (rst)
            snapshot <= '0;
        else if (load)
            snapshot <= bcdValue;
    end

    // Prescaler: counts 0..SCAN_DIV-1 and wraps; the last count marks a slot boundary.
    always_ff @(posedge clk) begin
        if (rst)
            scanCount <= '0;
        else if (scanCount == CNT_LAST)
            scanCount <= '0;
        else
            scanCount <= scanCount + CNT_W'(1);
    end

    assign tick = (scanCount == CNT_LAST);

    // Select the current digit's nibble and its one-hot anode (active-high form).
    always_comb begin
        curNibble = 4'd0;
        curAnode  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitIdx == IDX_W'(i)) begin
                curNibble   = snapshot[4*i +: 4];
                curAnode[i] = 1'b1;
            end
        end
    end

    // True when every digit from the current index up to the most significant is zero.
    always_comb begin
        upperZero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((IDX_W'(j) >= digitIdx) && (snapshot[4*j +: 4] != 4'd0))
                upperZero = 1'b0;
        end
    end

    // Digit 0 always shows, so an all-zero value still reads "0".
    assign curBlank = blankEn && (digitIdx != '0) && upperZero;
    assign curGlyph = decodeGlyph(curNibble);

    // Scan: on each slot boundary register the current digit onto the pins and advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            digitIdx <= '0;
            seg      <= SEG_OFF;
            an       <= AN_OFF;
        end else if (tick) begin
            if (curBlank) begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
            end else begin
                seg <= curGlyph ^ SEG_POL;
                an  <= curAnode ^ AN_POL;
            end
            if (digitIdx == IDX_LAST)
                digitIdx <= '0;
            else
                digitIdx <= digitIdx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Testbench for bcd_seg_scanner (DIGITS=3, SCAN_DIV=4, ACTIVE_LOW=1).
// A reference model predicts the pin state after every clock edge and queues it;
// a monitor pops one prediction per cycle and compares it with the pins.

module tb_bcd_seg_scanner;

    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic                clk = 1'b0;
    logic                rst;
    logic [4*DIGITS-1:0] bcdValue;
    logic                load;
    logic                blankEn;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [6+DIGITS:0] sbQ [$];

    // model state
    int          edgeCnt = 0;
    int          shownDigit = -1;
    logic [3:0]  snap [DIGITS];
    logic [6:0]  expSeg;
    logic [DIGITS-1:0] expAn;

    bcd_seg_scanner #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bcdValue(bcdValue),
        .load    (load),
        .blankEn (blankEn),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    // Reference model: slot timing from edge count since reset, glyphs from the table.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                edgeCnt    = 0;
                shownDigit = -1;
                for (int j = 0; j < DIGITS; j++) snap[j] = 4'd0;
                expSeg = 7'h7F;
                expAn  = '1;
            end else begin
                edgeCnt++;
                if (edgeCnt % SCAN_DIV == 0) begin
                    int  d;
                    bit  allZero;
                    d = ((edgeCnt / SCAN_DIV) - 1) % DIGITS;
                    allZero = 1'b1;
                    for (int j = d; j < DIGITS; j++)
                        if (snap[j] != 4'd0) allZero = 1'b0;
                    if (blankEn && d > 0 && allZero) begin
                        expSeg = 7'h7F;
                        expAn  = '1;
                    end else begin
                        expSeg = ~GLYPH[snap[d]];
                        expAn  = ~(DIGITS'(1) << d);
                    end
                    shownDigit = d;
                end
                if (load)
                    for (int j = 0; j < DIGITS; j++) snap[j] = bcdValue[4*j +: 4];
            end
            sbQ.push_back({expSeg, expAn});
        end
    end

    // Monitor: one prediction per edge, checked mid-cycle.
    initial begin
        logic [6+DIGITS:0] exp;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                testsRun++;
                if ({seg, an} !== exp) begin
                    testsFailed++;
                    if (testsFailed <= 20)
                        $display("FAIL pins @%0t: seg=%h an=%b, expected seg=%h an=%b",
                                 $time, seg, an, exp[6+DIGITS:DIGITS], exp[DIGITS-1:0]);
                end
            end
        end
    end

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseLoad(input logic [4*DIGITS-1:0] v);
        bcdValue = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        bcdValue = 'z;
    endtask

    // Leaves the bench just before an edge that will be a slot boundary.
    task automatic waitTickNext(output bit found);
        found = 1'b0;
        for (int k = 0; k < 4 * SCAN_DIV * DIGITS; k++) begin
            if ((edgeCnt + 1) % SCAN_DIV == 0) begin
                found = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkFound(input bit found, input string name);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("FAIL %s: wait expired, got none, expected event", name);
        end
    endtask

    initial begin
        bit found;
        rst      = 1'b1;
        load     = 1'b0;
        blankEn  = 1'b0;
        bcdValue = '0;
        runCycles(2);
        rst = 1'b0;
        bcdValue = 'z;
        runCycles(8);

        // count and plain digits
        pulseLoad(12'h123);
        runCycles(3 * SCAN_DIV * DIGITS);

        // leading-zero blanking on and off
        blankEn = 1'b1;
        pulseLoad(12'h007);
        runCycles(2 * SCAN_DIV * DIGITS);
        blankEn = 1'b0;
        runCycles(2 * SCAN_DIV * DIGITS);

        // dash glyph with blanking
        blankEn = 1'b1;
        pulseLoad(12'h0A5);
        runCycles(2 * SCAN_DIV * DIGITS);
        blankEn = 1'b0;

        // load coinciding with a slot boundary
        pulseLoad(12'h123);
        runCycles(SCAN_DIV * DIGITS);
        waitTickNext(found);
        checkFound(found, "tick_align");
        bcdValue = 12'h999;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        bcdValue = 'z;
        runCycles(2 * SCAN_DIV * DIGITS);

        // reset in the middle of the digit 1 slot
        found = 1'b0;
        for (int k = 0; k < 8 * SCAN_DIV * DIGITS; k++) begin
            if (shownDigit == 1 && edgeCnt % SCAN_DIV == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkFound(found, "mid_slot");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        runCycles(3 * SCAN_DIV * DIGITS);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                for (int j = 0; j < DIGITS; j++)
                    bcdValue[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                                         : 4'($urandom_range(0, 15));
            end else begin
                bcdValue = 'z;
            end
            if ($urandom_range(0, 15) == 0) blankEn = ~blankEn;
            @(negedge clk);
        end
        rst      = 1'b0;
        load     = 1'b0;
        bcdValue = 'z;
        runCycles(2);
        #1;
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("FAIL queue_drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "timeout");
    end

endmodule
